// File: rtl/exc_sequencer_pkg.sv
// Shared definitions for the exception sequencer: state encoding, COP0
// register indices, STATUS/CAUSE field positions and small field helpers.
package exc_sequencer_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned CODE_W = 5;
    localparam int unsigned CNT_W  = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_W_EPC,
        ST_W_BADV,
        ST_W_CAUSE,
        ST_W_STATUS,
        ST_E_STATUS,
        ST_REDIRECT,
        ST_MTC0
    } exc_state_e;

    localparam logic [REG_W-1:0] COP_EPC      = REG_W'(14);
    localparam logic [REG_W-1:0] COP_BADVADDR = REG_W'(8);
    localparam logic [REG_W-1:0] COP_CAUSE    = REG_W'(13);
    localparam logic [REG_W-1:0] COP_STATUS   = REG_W'(12);

    localparam int unsigned STATUS_EXL = 1;
    localparam int unsigned STATUS_UM  = 4;
    localparam int unsigned CAUSE_LSB  = 2;
    localparam int unsigned CAUSE_MSB  = 6;

    // One coprocessor register write
    typedef struct packed {
        logic             wen;
        logic [REG_W-1:0] wreg;
        logic [XLEN-1:0]  wdata;
    } cop_wr_t;

    function automatic logic [XLEN-1:0] cause_word(input logic [CODE_W-1:0] code);
        logic [XLEN-1:0] w;
        w = '0;
        w[CAUSE_MSB:CAUSE_LSB] = code;
        return w;
    endfunction

    // Entering kernel mode: set EXL, drop to kernel privilege
    function automatic logic [XLEN-1:0] status_enter(input logic [XLEN-1:0] s);
        logic [XLEN-1:0] r;
        r = s;
        r[STATUS_EXL] = 1'b1;
        r[STATUS_UM]  = 1'b0;
        return r;
    endfunction

    function automatic logic [XLEN-1:0] status_leave(input logic [XLEN-1:0] s);
        logic [XLEN-1:0] r;
        r = s;
        r[STATUS_EXL] = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/exc_sequencer.sv
// Exception / ERET / MTC0 sequencer that serialises COP0 updates onto a single
// write port and redirects the fetch PC. Outputs are registered from next-state decode.
module exc_sequencer
    import exc_sequencer_pkg::*;
#(
    parameter logic [31:0] KERNEL_PC = 32'h8000_0180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        exc_valid,
    input  logic [4:0]  exc_code,
    input  logic [31:0] exc_epc,
    input  logic [31:0] exc_badvaddr,
    input  logic        exc_has_badvaddr,
    input  logic        exc_level,
    input  logic [31:0] status_in,
    input  logic [31:0] epc_in,
    input  logic        eret,
    input  logic        mtc0_en,
    input  logic [4:0]  mtc0_reg,
    input  logic [31:0] mtc0_data,
    output logic        mtc0_ready,
    output logic        cop_wen,
    output logic [4:0]  cop_wreg,
    output logic [31:0] cop_wdata,
    output logic        flush,
    output logic        stall,
    output logic        pc_redirect,
    output logic [31:0] pc_target,
    output logic [7:0]  dropped_cnt
);

    exc_state_e          state, state_n;
    cop_wr_t             wr_q, wr_n;
    logic                flush_q, flush_n;
    logic                stall_q, stall_n;
    logic                redir_q, redir_n;
    logic [XLEN-1:0]     target_q, target_n;
    logic                exc_take;

    logic [CODE_W-1:0]   lat_code;
    logic [XLEN-1:0]     lat_badvaddr;
    logic                lat_has_badvaddr;
    logic [CNT_W-1:0]    dropped_q;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state plus next-cycle output values
    always_comb begin
        state_n    = state;
        wr_n       = '0;
        flush_n    = 1'b0;
        redir_n    = 1'b0;
        target_n   = '0;
        exc_take   = 1'b0;
        mtc0_ready = 1'b0;

        case (state)
            ST_IDLE: begin
                if (exc_valid && !exc_level) begin
                    exc_take = 1'b1;
                    state_n  = ST_W_EPC;
                    wr_n     = '{wen: 1'b1, wreg: COP_EPC, wdata: exc_epc};
                    flush_n  = 1'b1;
                end else if (eret && exc_level) begin
                    state_n = ST_E_STATUS;
                    wr_n    = '{wen: 1'b1, wreg: COP_STATUS, wdata: status_leave(status_in)};
                end else begin
                    mtc0_ready = 1'b1;
                    if (mtc0_en) begin
                        state_n = ST_MTC0;
                        wr_n    = '{wen: 1'b1, wreg: mtc0_reg, wdata: mtc0_data};
                    end
                end
            end
            ST_W_EPC: begin
                if (lat_has_badvaddr) begin
                    state_n = ST_W_BADV;
                    wr_n    = '{wen: 1'b1, wreg: COP_BADVADDR, wdata: lat_badvaddr};
                end else begin
                    state_n = ST_W_CAUSE;
                    wr_n    = '{wen: 1'b1, wreg: COP_CAUSE, wdata: cause_word(lat_code)};
                end
            end
            ST_W_BADV: begin
                state_n = ST_W_CAUSE;
                wr_n    = '{wen: 1'b1, wreg: COP_CAUSE, wdata: cause_word(lat_code)};
            end
            ST_W_CAUSE: begin
                state_n = ST_W_STATUS;
                wr_n    = '{wen: 1'b1, wreg: COP_STATUS, wdata: status_enter(status_in)};
            end
            ST_W_STATUS: begin
                state_n  = ST_REDIRECT;
                redir_n  = 1'b1;
                target_n = KERNEL_PC;
            end
            ST_E_STATUS: begin
                state_n  = ST_REDIRECT;
                redir_n  = 1'b1;
                target_n = epc_in;
            end
            ST_REDIRECT: state_n = ST_IDLE;
            ST_MTC0:     state_n = ST_IDLE;
            default:     state_n = ST_IDLE;
        endcase

        stall_n = (state_n != ST_IDLE);
    end

    // Output registers, exception attribute latches and drop counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q             <= '0;
            flush_q          <= 1'b0;
            stall_q          <= 1'b0;
            redir_q          <= 1'b0;
            target_q         <= '0;
            lat_code         <= '0;
            lat_badvaddr     <= '0;
            lat_has_badvaddr <= 1'b0;
            dropped_q        <= '0;
        end else begin
            wr_q     <= wr_n;
            flush_q  <= flush_n;
            stall_q  <= stall_n;
            redir_q  <= redir_n;
            target_q <= target_n;
            if (exc_take) begin
                lat_code         <= exc_code;
                lat_badvaddr     <= exc_badvaddr;
                lat_has_badvaddr <= exc_has_badvaddr;
            end
            if (exc_valid && !exc_take && (dropped_q != '1)) begin
                dropped_q <= dropped_q + CNT_W'(1);
            end
        end
    end

    assign cop_wen     = wr_q.wen;
    assign cop_wreg    = wr_q.wreg;
    assign cop_wdata   = wr_q.wdata;
    assign flush       = flush_q;
    assign stall       = stall_q;
    assign pc_redirect = redir_q;
    assign pc_target   = target_q;
    assign dropped_cnt = dropped_q;

endmodule

// File: tb/tb_exc_sequencer.sv
// Self-checking bench for exc_sequencer: directed scenarios plus random traffic,
// compared each cycle against a transaction-level model of expected writes.
module tb_exc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        exc_valid, exc_has_badvaddr, exc_level, eret, mtc0_en;
    logic [4:0]  exc_code, mtc0_reg;
    logic [31:0] exc_epc, exc_badvaddr, status_in, epc_in, mtc0_data;
    logic        mtc0_ready, cop_wen, flush, stall, pc_redirect;
    logic [4:0]  cop_wreg;
    logic [31:0] cop_wdata, pc_target;
    logic [7:0]  dropped_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    exc_sequencer #(.KERNEL_PC(32'h8000_0180)) dut (
        .clk(clk), .reset(reset),
        .exc_valid(exc_valid), .exc_code(exc_code), .exc_epc(exc_epc),
        .exc_badvaddr(exc_badvaddr), .exc_has_badvaddr(exc_has_badvaddr),
        .exc_level(exc_level), .status_in(status_in), .epc_in(epc_in),
        .eret(eret), .mtc0_en(mtc0_en), .mtc0_reg(mtc0_reg), .mtc0_data(mtc0_data),
        .mtc0_ready(mtc0_ready), .cop_wen(cop_wen), .cop_wreg(cop_wreg),
        .cop_wdata(cop_wdata), .flush(flush), .stall(stall),
        .pc_redirect(pc_redirect), .pc_target(pc_target), .dropped_cnt(dropped_cnt)
    );

    // Expected outputs for one cycle; busy marks a cycle spent outside IDLE
    typedef struct {
        bit        busy;
        bit        wen;
        bit [4:0]  wreg;
        bit [31:0] wdata;
        bit        flush;
        bit        redir;
        bit [31:0] target;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        cur;
    int unsigned m_drop;
    bit          m_took_mtc0;

    function automatic exp_t idle_ev();
        exp_t e;
        e.busy = 0; e.wen = 0; e.wreg = 0; e.wdata = 0;
        e.flush = 0; e.redir = 0; e.target = 0;
        return e;
    endfunction

    function automatic exp_t wr_ev(input bit [4:0] r, input bit [31:0] d, input bit fl);
        exp_t e;
        e = idle_ev();
        e.busy = 1; e.wen = 1; e.wreg = r; e.wdata = d; e.flush = fl;
        return e;
    endfunction

    function automatic exp_t redir_ev(input bit [31:0] t);
        exp_t e;
        e = idle_ev();
        e.busy = 1; e.redir = 1; e.target = t;
        return e;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Schedule the writes a transaction accepted this cycle will produce
    task automatic model_cycle();
        bit idle;
        idle = !cur.busy;
        m_took_mtc0 = 0;
        if (exc_valid && !(idle && !exc_level) && m_drop < 255) m_drop++;
        if (idle) begin
            if (exc_valid && !exc_level) begin
                exp_q.push_back(wr_ev(5'd14, exc_epc, 1'b1));
                if (exc_has_badvaddr) exp_q.push_back(wr_ev(5'd8, exc_badvaddr, 1'b0));
                exp_q.push_back(wr_ev(5'd13, 32'(exc_code) * 32'd4, 1'b0));
                exp_q.push_back(wr_ev(5'd12, (status_in | 32'h2) & ~32'h10, 1'b0));
                exp_q.push_back(redir_ev(32'h8000_0180));
            end else if (eret && exc_level) begin
                exp_q.push_back(wr_ev(5'd12, status_in & ~32'h2, 1'b0));
                exp_q.push_back(redir_ev(epc_in));
            end else if (mtc0_en) begin
                exp_q.push_back(wr_ev(mtc0_reg, mtc0_data, 1'b0));
                m_took_mtc0 = 1;
            end
        end
    endtask

    task automatic check_outputs();
        check("cop_wen",     64'(cop_wen),     64'(cur.wen));
        check("cop_wreg",    64'(cop_wreg),    64'(cur.wreg));
        check("cop_wdata",   64'(cop_wdata),   64'(cur.wdata));
        check("flush",       64'(flush),       64'(cur.flush));
        check("stall",       64'(stall),       64'(cur.busy));
        check("pc_redirect", 64'(pc_redirect), 64'(cur.redir));
        check("pc_target",   64'(pc_target),   64'(cur.target));
        check("dropped_cnt", 64'(dropped_cnt), 64'(m_drop));
    endtask

    // Inputs are already driven; check ready, advance model and DUT one cycle
    task automatic step();
        bit exp_ready;
        #1;
        exp_ready = !cur.busy && !(exc_valid && !exc_level) && !(eret && exc_level);
        check("mtc0_ready", 64'(mtc0_ready), 64'(exp_ready));
        model_cycle();
        @(posedge clk);
        #1;
        cur = (exp_q.size() != 0) ? exp_q.pop_front() : idle_ev();
        check_outputs();
    endtask

    task automatic clear_inputs();
        exc_valid = 0; exc_has_badvaddr = 0; exc_level = 0; eret = 0; mtc0_en = 0;
        exc_code = 0; mtc0_reg = 0; exc_epc = 0; exc_badvaddr = 0; mtc0_data = 0;
    endtask

    task automatic drain();
        clear_inputs();
        for (int i = 0; i < 16 && cur.busy; i++) step();
        check("drain_stall", 64'(stall), 64'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        clear_inputs();
        status_in = 0; epc_in = 0;
        exp_q.delete();
        cur = idle_ev();
        m_drop = 0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        reset = 1'b0;

        // Exception without bad address: EPC, CAUSE, STATUS, redirect
        status_in = 32'h0000_FF11;
        exc_valid = 1; exc_code = 5'd12; exc_epc = 32'h0040_0010;
        step();
        check("t029_epc_reg",  64'(cop_wreg),  64'(14));
        check("t029_epc_data", 64'(cop_wdata), 64'(32'h0040_0010));
        clear_inputs();
        step();
        check("t029_cause", 64'(cop_wdata), 64'(32'h0000_0030));
        step();
        check("t029_status", 64'(cop_wdata), 64'(32'h0000_FF03));
        step();
        check("t029_redir", 64'(pc_target), 64'(32'h8000_0180));
        drain();

        // Address-load exception with bad address
        exc_valid = 1; exc_code = 5'd4; exc_epc = 32'h0040_0020;
        exc_badvaddr = 32'h1000_0003; exc_has_badvaddr = 1;
        step();
        clear_inputs();
        step();
        check("t030_badv_reg",  64'(cop_wreg),  64'(8));
        check("t030_badv_data", 64'(cop_wdata), 64'(32'h1000_0003));
        repeat (3) step();
        check("t030_redir", 64'(pc_redirect), 64'(1));
        drain();

        // ERET with EXL set
        status_in = 32'h0000_0013; epc_in = 32'h0040_0014;
        exc_level = 1; eret = 1;
        step();
        check("t031_status", 64'(cop_wdata), 64'(32'h0000_0011));
        clear_inputs();
        step();
        check("t031_target", 64'(pc_target), 64'(32'h0040_0014));
        drain();

        // ERET ignored with EXL clear
        eret = 1;
        step();
        check("eret_ignored", 64'(stall), 64'(0));
        drain();

        // MTC0 held off during an exception sequence
        exc_valid = 1; exc_code = 5'd8; exc_epc = 32'h0040_0030;
        mtc0_en = 1; mtc0_reg = 5'd9; mtc0_data = 32'h0000_ABCD;
        step();
        exc_valid = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (m_took_mtc0) break;
        end
        check("t032_reg",  64'(cop_wreg),  64'(9));
        check("t032_data", 64'(cop_wdata), 64'(32'h0000_ABCD));
        mtc0_en = 0;
        step();
        check("t032_single", 64'(cop_wen), 64'(0));
        drain();

        // Dropped exceptions saturate
        exc_valid = 1; exc_level = 1;
        for (int i = 0; i < 300; i++) begin
            exc_code = 5'($urandom);
            exc_epc  = $urandom;
            step();
        end
        check("t033_sat", 64'(dropped_cnt), 64'(255));
        drain();

        // Reset during W_CAUSE abandons the sequence
        exc_valid = 1; exc_code = 5'd10; exc_epc = 32'h0040_0040;
        step();
        clear_inputs();
        step();
        #2;
        reset = 1'b1;
        #1;
        check("t034_wen",   64'(cop_wen),     64'(0));
        check("t034_wreg",  64'(cop_wreg),    64'(0));
        check("t034_wdata", 64'(cop_wdata),   64'(0));
        check("t034_stall", 64'(stall),       64'(0));
        check("t034_redir", 64'(pc_redirect), 64'(0));
        check("t034_drop",  64'(dropped_cnt), 64'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        cur = idle_ev();
        m_drop = 0;
        repeat (6) step();

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            if (!cur.busy) begin
                status_in = $urandom;
                epc_in    = $urandom;
            end
            exc_valid        = ($urandom_range(0, 3) == 0);
            exc_level        = ($urandom_range(0, 2) == 0);
            eret             = ($urandom_range(0, 3) == 0);
            mtc0_en          = ($urandom_range(0, 2) == 0);
            exc_has_badvaddr = $urandom_range(0, 1) == 1;
            exc_code         = 5'($urandom);
            exc_epc          = $urandom;
            exc_badvaddr     = $urandom;
            mtc0_reg         = 5'($urandom);
            mtc0_data        = $urandom;
            step();
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
